// File: rtl/contador_sincrono_crescente.sv
// Synchronous modulo-MODULO up counter with parallel load, cascade terminal count,
// wrap pulse, sticky overflow and load-error pulse. Define CONTADOR_SATURA_EN to saturate instead of wrapping.
module contador_sincrono_crescente #(
  parameter int WIDTH  = 4,
  parameter int MODULO = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             ovf,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULO - 1);
  // One extra bit so MODULO == 2**WIDTH is representable in the load-range compare.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             load_err_q, load_err_d;
  logic             at_top;
  logic             load_ok;

  assign at_top  = (q_q == TOP);
  assign load_ok = ({1'b0, d} < MOD_EXT);

  // NOTE: every next-state signal gets a default first, so no path leaves it unassigned (no latch);
  // blocking assignments are correct here because this block is combinational.
  always_comb begin
    q_d        = q_q;
    wrap_d     = 1'b0;
    ovf_d      = ovf_q;
    load_err_d = 1'b0;

    if (clr_ovf) ovf_d = 1'b0;

    if (load) begin
      if (load_ok) q_d = d;
      else         load_err_d = 1'b1;
    end else if (en) begin
      if (at_top) begin
`ifdef CONTADOR_SATURA_EN
        q_d    = q_q;
        ovf_d  = 1'b1;
`else
        q_d    = '0;
        wrap_d = 1'b1;
        ovf_d  = 1'b1;
`endif
      end else begin
        q_d = q_q + WIDTH'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q        <= '0;
      wrap_q     <= 1'b0;
      ovf_q      <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      wrap_q     <= wrap_d;
      ovf_q      <= ovf_d;
      load_err_q <= load_err_d;
    end
  end

  // Combinational so a downstream stage enabled by tc advances on this same edge.
  assign tc       = at_top && en;
  assign q        = q_q;
  assign wrap     = wrap_q;
  assign ovf      = ovf_q;
  assign load_err = load_err_q;

endmodule
